// File: rtl/param_binary_counter_if.sv
// param_binary_counter_if: control/status bundle for param_binary_counter.
//   master drives start/stop/enable/up_down/mode/load/load_value/clear.
//   slave drives count/result/overflow/busy/done.
interface param_binary_counter_if #(parameter int WIDTH = 6);
  logic start, stop, enable, up_down, load, clear;
  logic [1:0] mode;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic result, overflow, busy, done;
  modport master (
    output start, stop, enable, up_down, mode, load, load_value, clear,
    input  count, result, overflow, busy, done
  );
  modport slave (
    input  start, stop, enable, up_down, mode, load, load_value, clear,
    output count, result, overflow, busy, done
  );
endinterface

// File: rtl/param_binary_counter.sv
// param_binary_counter: up/down counter with wrap/saturate/one-shot/auto-reload modes and run control.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : slave side of param_binary_counter_if
//                  inputs start/stop/enable/up_down/mode/load/load_value/clear
//                  outputs count (registered), result (terminal pulse), overflow (sticky),
//                  busy (RUN), done (DONE)
module param_binary_counter #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 63
) (
  input logic clock,
  input logic reset,
  param_binary_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);
  state_t state;
  logic [WIDTH-1:0] count, reload;
  logic result, overflow, at_term;
  assign reload = bus.load_value > MAXC ? MAXC : bus.load_value;
  // Anything above MAX_COUNT counts as terminal going up, so a stray value can never run away.
  assign at_term = bus.up_down ? count >= MAXC : count == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count    <= '0;
      result   <= 1'b0;
      overflow <= 1'b0;
      state    <= IDLE;
    end else if (bus.clear) begin
      count    <= '0;
      result   <= 1'b0;
      overflow <= 1'b0;
    end else if (bus.load) begin
      count  <= reload;
      result <= 1'b0;
    end else if (bus.stop) begin
      state  <= IDLE;
      result <= 1'b0;
    end else if (bus.start && state != RUN) begin
      count  <= state == DONE ? reload : count;
      state  <= RUN;
      result <= 1'b0;
    end else if (state == RUN && bus.enable) begin
      result <= at_term;
      if (at_term) begin
        overflow <= 1'b1;
        count    <= bus.mode == 2'b00 ? (bus.up_down ? '0 : MAXC) :
                    bus.mode == 2'b11 ? reload : count;
        if (bus.mode == 2'b10) state <= DONE;
      end else begin
        count <= bus.up_down ? count + 1'b1 : count - 1'b1;
      end
    end else begin
      result <= 1'b0;
    end
  assign bus.count    = count;
  assign bus.result   = result;
  assign bus.overflow = overflow;
  assign bus.busy     = state == RUN;
  assign bus.done     = state == DONE;
endmodule
